scr1_dmem_ahb_sram: RTL and testbench
=====================================

Name: scr1_dmem_ahb_sram

Overview:
- AHB-Lite slave that terminates the data-memory AHB master port and fronts a single-port synchronous SRAM.
- The SRAM has 1-cycle read latency and byte-write enables.
- Reads complete with zero wait states. Writes are performed in their data phase.
- Error responses are returned for misaligned, oversize or out-of-range transfers.

Parameters:
MEM_AW, 14, SRAM word-address width (memory size = 4*2^MEM_AW bytes; default 64 KiB)
BASE_ADDR, 32'h0000_0000, byte base address of the SRAM window; must be aligned to the memory size

Ports:
clk  in  1  core clock
rst_n  in  1  reset, synchronous, active-low
hsel  in  1  slave select
htrans  in  2  AHB transfer type
hsize  in  3  AHB transfer size
haddr  in  32  AHB address
hwrite  in  1  1 = write
hwdata  in  32  write data (data phase), lanes already placed per address
hready_in  in  1  bus HREADY (previous transfer complete)
hready  out  1  slave HREADYOUT
hresp  out  1  0 = OKAY, 1 = ERROR
hrdata  out  32  read data, full word, unshifted
mem_req  out  1  SRAM access strobe
mem_we  out  1  SRAM write enable
mem_be  out  4  SRAM byte enables
mem_addr  out  MEM_AW  SRAM word address
mem_wdata  out  32  SRAM write data
mem_rdata  in  32  SRAM read data, valid the cycle after mem_req & ~mem_we

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is synchronous, active-low.
- Reset values: state = IDLE, hready = 1, hresp = 0, mem_req = 0, mem_we = 0, hrdata = 0.
- Address-phase accept: acc = hsel & htrans[1] & hready_in. IDLE/BUSY transfers or hsel = 0 give an OKAY zero-wait response with no memory access.
- Error check at accept: error if any of the following holds:
  - hsize > 3'b010;
  - hsize = 16B and haddr[0] = 1;
  - hsize = 32B and haddr[1:0] != 0;
  - haddr outside [BASE_ADDR, BASE_ADDR + 4*2^MEM_AW).
- Byte enables are registered at accept:
  - 8B: 4'b0001 << haddr[1:0];
  - 16B: haddr[1] ? 4'b1100 : 4'b0011;
  - 32B: 4'b1111.
- Word address = haddr[MEM_AW+1:2].
- States:
  - IDLE: no transfer in data phase.
  - RD: read data phase. SRAM read was issued combinationally in the address phase (mem_req = 1, mem_we = 0). hready = 1, hrdata = mem_rdata.
  - WR: write data phase. mem_req = 1, mem_we = 1, mem_wdata = hwdata, registered be/addr used. hready = 1.
  - RD_LATE: read accepted while WR occupies the SRAM port. Issue the read this cycle; hready = 0.
  - RD_FIN: after RD_LATE, hready = 1, hrdata = mem_rdata.
  - ERR1: hready = 0, hresp = 1.
  - ERR2: hready = 1, hresp = 1.
- Transitions are evaluated on acc:
  - Error transfer -> ERR1 -> ERR2.
  - Write -> WR.
  - Read -> RD, or RD_LATE if the current state is WR.
  - No acc and hready = 1 -> IDLE.
  - ERR2 and RD_FIN accept a new transfer on the same rules.
- Address-phase read issue: happens only when the current state is not WR. The SRAM port is never driven by two accesses in one cycle.
- Back-to-back writes: each completes in its own data phase, zero wait.
- Read after write: the write commits in cycle N; the read SRAM access occurs in cycle N+1. No forwarding is needed.
- The slave never issues an SRAM access for an erroring transfer.
- hrdata:
  - Holds its last value in all states except RD and RD_FIN. It is registered in those states only for the value seen by downstream logic.
  - Combinational pass-through in RD and RD_FIN is permitted: hrdata = mem_rdata.
- While hready = 0 the slave ignores address-phase inputs. AHB master rules keep them stable.
- Reset asserted mid-transfer: state -> IDLE next edge; a WR data phase in progress is dropped (mem_req = 0 that cycle onward); no SRAM write occurs after the reset edge.
- hburst, hprot and hmastlock are not used; bursts are treated as independent NONSEQ/SEQ beats.

Test Plan:
- Reset, then a 32B read of 0x0000_0010 with SRAM word 4 = 0xDEADBEEF -> mem_req&~mem_we, mem_addr = 4 in the address cycle; next cycle hready = 1, hresp = 0, hrdata = 0xDEADBEEF.
- Byte write 0xAB to 0x0000_0003, hwdata = 0xAB00_0000 -> in the data phase mem_we = 1, mem_be = 4'b1000, mem_addr = 0, mem_wdata = 0xAB00_0000, hready = 1.
- Write 0x1234_5678 to 0x20 immediately followed by a read of 0x20 -> write commits in cycle N; read shows hready = 0 in N+1, hready = 1 with hrdata = 0x1234_5678 in N+2.
- 32B read of 0x0000_0002 (misaligned), then 16B read at 0x0001_0000 with MEM_AW = 14 (out of range) -> each gives hready 0/1 with hresp 1/1 over two cycles, and mem_req stays 0.
- Four back-to-back 16B writes at 0x0, 0x2, 0x4, 0x6 -> mem_be = 0011, 1100, 0011, 1100 on consecutive cycles; zero wait states; hresp = 0 throughout.
- rst_n low during a WR data phase -> mem_req = 0 from the cycle after the reset edge, hready = 1, hresp = 0; the SRAM word is unchanged.

Source files
------------

// File: rtl/scr1_dmem_ahb_sram_if.sv
// scr1_dmem_ahb_sram_if: AHB-Lite data-memory bus plus single-port SRAM port bundle.
//   AHB : hsel, htrans, hsize, haddr, hwrite, hwdata, hready_in (master -> slave)
//         hready, hresp, hrdata                                  (slave -> master)
//   SRAM: mem_req, mem_we, mem_be, mem_addr, mem_wdata           (slave -> memory)
//         mem_rdata                                              (memory -> slave)
interface scr1_dmem_ahb_sram_if #(
   parameter int MEM_AW = 14
);
   logic              hsel;
   logic [1:0]        htrans;
   logic [2:0]        hsize;
   logic [31:0]       haddr;
   logic              hwrite;
   logic [31:0]       hwdata;
   logic              hready_in;
   logic              hready;
   logic              hresp;
   logic [31:0]       hrdata;
   logic              mem_req;
   logic              mem_we;
   logic [3:0]        mem_be;
   logic [MEM_AW-1:0] mem_addr;
   logic [31:0]       mem_wdata;
   logic [31:0]       mem_rdata;
   modport slave (
      input  hsel, htrans, hsize, haddr, hwrite, hwdata, hready_in, mem_rdata,
      output hready, hresp, hrdata, mem_req, mem_we, mem_be, mem_addr, mem_wdata
   );
   modport master (
      output hsel, htrans, hsize, haddr, hwrite, hwdata, hready_in, mem_rdata,
      input  hready, hresp, hrdata, mem_req, mem_we, mem_be, mem_addr, mem_wdata
   );
endinterface

// File: rtl/scr1_dmem_ahb_sram.sv
// scr1_dmem_ahb_sram: AHB-Lite slave fronting a 1-cycle-latency single-port SRAM.
//   clk    : core clock
//   rst_n  : synchronous active-low reset
//   io_ahb : AHB slave side and SRAM request side (see scr1_dmem_ahb_sram_if)
// Reads are issued in the address phase and return with zero wait states unless
// the SRAM port is busy with a write data phase, in which case one wait is added.
module scr1_dmem_ahb_sram #(
   parameter int          MEM_AW    = 14,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input  logic                 clk,
   input  logic                 rst_n,
   scr1_dmem_ahb_sram_if.slave  io_ahb
);
   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] RD      = 3'd1;
   localparam logic [2:0] WR      = 3'd2;
   localparam logic [2:0] RD_LATE = 3'd3;
   localparam logic [2:0] RD_FIN  = 3'd4;
   localparam logic [2:0] ERR1    = 3'd5;
   localparam logic [2:0] ERR2    = 3'd6;

   logic [2:0]        r_state;
   logic [2:0]        w_next;
   logic [3:0]        r_be;
   logic [3:0]        w_be;
   logic [MEM_AW-1:0] r_addr;
   logic [MEM_AW-1:0] w_addr;
   logic [31:0]       r_hrdata;
   logic              w_hready;
   logic              w_acc;
   logic              w_err;
   logic              w_oor;
   logic              w_rd_ph;
   logic              w_rd_issue;
   logic              w_wr_ph;

   assign w_hready = ~(r_state == ERR1 || r_state == RD_LATE);
   // Our own stall also gates accept, so held address-phase inputs are ignored.
   assign w_acc    = io_ahb.hsel & (io_ahb.htrans inside {2'b10, 2'b11}) & io_ahb.hready_in & w_hready;
   // Window offset; addresses below the base wrap to large offsets and fail too.
   assign w_oor    = (io_ahb.haddr - BASE_ADDR) >= (32'd4 << MEM_AW);
   assign w_err    = (io_ahb.hsize > 3'b010)
                   | (io_ahb.hsize == 3'b001 && io_ahb.haddr[0])
                   | (io_ahb.hsize == 3'b010 && io_ahb.haddr[1:0] != 2'b00)
                   | w_oor;
   assign w_be     = io_ahb.hsize == 3'b000 ? 4'b0001 << io_ahb.haddr[1:0]
                   : io_ahb.hsize == 3'b001 ? (io_ahb.haddr[1] ? 4'b1100 : 4'b0011)
                   : 4'b1111;
   assign w_addr   = io_ahb.haddr[MEM_AW+1:2];
   assign w_wr_ph  = r_state == WR;
   assign w_rd_ph  = r_state == RD || r_state == RD_FIN;
   // A write data phase owns the SRAM port; a read arriving then is deferred.
   assign w_rd_issue = w_acc & ~w_err & ~io_ahb.hwrite & ~w_wr_ph;

   always_comb
      w_next = !w_hready  ? (r_state == ERR1 ? ERR2 : RD_FIN)
             : !w_acc     ? IDLE
             : w_err      ? ERR1
             : io_ahb.hwrite ? WR
             : w_wr_ph    ? RD_LATE
             : RD;

   always_ff @(posedge clk)
      if (!rst_n) begin
         r_state  <= IDLE;
         r_be     <= '0;
         r_addr   <= '0;
         r_hrdata <= '0;
      end else begin
         r_state <= w_next;
         if (w_acc) begin
            r_be   <= w_be;
            r_addr <= w_addr;
         end
         if (w_rd_ph) r_hrdata <= io_ahb.mem_rdata;
      end

   assign io_ahb.hready    = w_hready;
   assign io_ahb.hresp     = r_state == ERR1 || r_state == ERR2;
   assign io_ahb.hrdata    = w_rd_ph ? io_ahb.mem_rdata : r_hrdata;
   // Gating with rst_n drops an in-flight write at the reset edge itself.
   assign io_ahb.mem_req   = rst_n & (w_wr_ph | r_state == RD_LATE | w_rd_issue);
   assign io_ahb.mem_we    = rst_n & w_wr_ph;
   assign io_ahb.mem_be    = w_wr_ph ? r_be : 4'b1111;
   assign io_ahb.mem_addr  = (w_wr_ph || r_state == RD_LATE) ? r_addr : w_addr;
   assign io_ahb.mem_wdata = io_ahb.hwdata;
endmodule

// File: tb/tb_scr1_dmem_ahb_sram.sv
// tb_scr1_dmem_ahb_sram: directed and randomized bench for scr1_dmem_ahb_sram.
module tb_scr1_dmem_ahb_sram;
   localparam int AW = 14;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   scr1_dmem_ahb_sram_if #(.MEM_AW(AW)) bus ();
   scr1_dmem_ahb_sram #(.MEM_AW(AW), .BASE_ADDR(32'h0)) dut (.clk(clk), .rst_n(rst_n), .io_ahb(bus));
   assign bus.hready_in = bus.hready;

   int checks = 0;
   int errors = 0;
   bit do_init = 1'b0;
   bit model_on = 1'b0;
   bit adv;
   logic [31:0] sram [0:(1<<AW)-1];
   logic [31:0] ref_mem [0:(1<<AW)-1];
   logic [31:0] rd_q;
   logic [31:0] last_rd;
   bit ap_v, ap_err, ap_wr;
   logic [31:0] ap_addr;
   logic [2:0] ap_size;
   bit dp_v, dp_err, dp_wr, dp_late, was_wr;
   logic [31:0] dp_addr, dp_wdata;
   logic [3:0] dp_be;
   int dp_cyc;
   bit wr_dp, wait_c, e_rdy, e_resp, e_req, fin_rd;
   logic [31:0] e_rd;
   logic [AW-1:0] e_addr;

   function automatic logic [31:0] pat(input int i);
      return i == 4 ? 32'hDEAD_BEEF : 32'(i) * 32'h9E37_79B1 + 32'h0000_1357;
   endfunction
   function automatic bit err_of(input logic [2:0] s, input logic [31:0] a);
      return s > 3'd2 || (s == 3'd1 && a[0]) || (s == 3'd2 && a[1:0] != 2'b00) || a >= 32'h0001_0000;
   endfunction
   function automatic logic [3:0] be_of(input logic [2:0] s, input logic [1:0] lo);
      return s == 3'd0 ? 4'b0001 << lo : s == 3'd1 ? (lo[1] ? 4'b1100 : 4'b0011) : 4'b1111;
   endfunction

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
      end
   endtask

   // SRAM model: 1-cycle read latency, byte write enables
   always @(posedge clk)
      if (do_init) begin
         for (int i = 0; i < (1 << AW); i++) sram[i] <= pat(i);
      end else if (bus.mem_req) begin
         if (bus.mem_we) begin
            for (int b = 0; b < 4; b++) if (bus.mem_be[b]) sram[bus.mem_addr][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
         end else rd_q <= sram[bus.mem_addr];
      end
   assign bus.mem_rdata = rd_q;

   // Reference model and compare: expectation per data-phase transfer
   always @(negedge clk) begin
      if (do_init) for (int i = 0; i < (1 << AW); i++) ref_mem[i] = pat(i);
      if (!rst_n) last_rd = '0;
      if (!rst_n || !model_on) adv = 1'b1;
      else begin
         wr_dp  = dp_v && !dp_err && dp_wr;
         wait_c = dp_v && !dp_err && !dp_wr && dp_late && dp_cyc == 0;
         e_rdy  = !(wait_c || (dp_v && dp_err && dp_cyc == 0));
         e_resp = dp_v && dp_err;
         fin_rd = dp_v && !dp_err && !dp_wr && e_rdy;
         e_rd   = fin_rd ? ref_mem[dp_addr[AW+1:2]] : last_rd;
         e_req  = wr_dp || wait_c || (e_rdy && ap_v && !ap_err && !ap_wr);
         e_addr = (wr_dp || wait_c) ? dp_addr[AW+1:2] : ap_addr[AW+1:2];
         chk("hready", 32'(bus.hready), 32'(e_rdy));
         chk("hresp", 32'(bus.hresp), 32'(e_resp));
         chk("hrdata", bus.hrdata, e_rd);
         chk("mem_req", 32'(bus.mem_req), 32'(e_req));
         if (e_req) begin
            chk("mem_we", 32'(bus.mem_we), 32'(wr_dp));
            chk("mem_addr", 32'(bus.mem_addr), 32'(e_addr));
         end
         if (wr_dp) begin
            chk("mem_be", 32'(bus.mem_be), 32'(dp_be));
            chk("mem_wdata", bus.mem_wdata, dp_wdata);
            for (int b = 0; b < 4; b++) if (dp_be[b]) ref_mem[dp_addr[AW+1:2]][8*b +: 8] = dp_wdata[8*b +: 8];
         end
         if (fin_rd) last_rd = e_rd;
         adv = e_rdy;
      end
   end

   task automatic ap_set(input bit sel, input logic [1:0] tr, input logic [2:0] sz, input logic [31:0] a, input bit wr);
      bus.hsel = sel; bus.htrans = tr; bus.hsize = sz; bus.haddr = a; bus.hwrite = wr;
   endtask
   task automatic idle();
      ap_set(1'b0, 2'b00, 3'd0, 32'h0, 1'b0);
   endtask
   task automatic nxt();
      @(posedge clk); #1;
   endtask
   task automatic smp();
      @(negedge clk);
   endtask

   task automatic gen(input bit quiet);
      int r;
      logic [31:0] a;
      logic [2:0] sz;
      r  = int'($urandom_range(0, 99));
      sz = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
      if ($urandom_range(0, 11) == 0) a = $urandom | 32'h0001_0000;
      else begin
         a = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
         if (sz == 3'd0 || $urandom_range(0, 4) == 0) a[1:0] = 2'($urandom);
         else if (sz == 3'd1) a[1] = 1'($urandom);
      end
      ap_v = !quiet && r >= 20;
      if (quiet) ap_set(1'b0, 2'b00, sz, a, 1'b0);
      else if (ap_v) ap_set(1'b1, {1'b1, 1'($urandom)}, sz, a, 1'($urandom));
      else if (r < 10) ap_set(1'b0, 2'($urandom), sz, a, 1'($urandom));
      else ap_set(1'b1, {1'b0, 1'($urandom)}, sz, a, 1'($urandom));
      ap_wr = bus.hwrite; ap_addr = a; ap_size = sz; ap_err = err_of(sz, a);
   endtask

   initial begin
      idle(); bus.hwdata = '0;
      ap_v = 0; ap_err = 0; ap_wr = 0; ap_addr = '0; ap_size = '0;
      dp_v = 0; dp_err = 0; dp_wr = 0; dp_late = 0; dp_addr = '0; dp_wdata = '0; dp_be = '0; dp_cyc = 0;
      do_init = 1'b1; repeat (2) nxt(); do_init = 1'b0; nxt(); rst_n = 1'b1;
      smp();
      chk("rst_hready", 32'(bus.hready), 32'd1);
      chk("rst_hresp", 32'(bus.hresp), 32'd0);
      chk("rst_hrdata", bus.hrdata, 32'd0);
      chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
      // word read of 0x10
      nxt(); ap_set(1'b1, 2'b10, 3'd2, 32'h10, 1'b0); smp();
      chk("rd_req", 32'(bus.mem_req & ~bus.mem_we), 32'd1);
      chk("rd_addr", 32'(bus.mem_addr), 32'd4);
      nxt(); idle(); smp();
      chk("rd_hready", 32'(bus.hready), 32'd1);
      chk("rd_hresp", 32'(bus.hresp), 32'd0);
      chk("rd_hrdata", bus.hrdata, 32'hDEAD_BEEF);
      // byte write to 0x3
      nxt(); ap_set(1'b1, 2'b10, 3'd0, 32'h3, 1'b1);
      nxt(); idle(); bus.hwdata = 32'hAB00_0000; smp();
      chk("bw_we", 32'(bus.mem_req & bus.mem_we), 32'd1);
      chk("bw_be", 32'(bus.mem_be), 32'h8);
      chk("bw_addr", 32'(bus.mem_addr), 32'd0);
      chk("bw_wdata", bus.mem_wdata, 32'hAB00_0000);
      chk("bw_hready", 32'(bus.hready), 32'd1);
      // write then read of 0x20
      nxt(); ap_set(1'b1, 2'b10, 3'd2, 32'h20, 1'b1);
      nxt(); ap_set(1'b1, 2'b10, 3'd2, 32'h20, 1'b0); bus.hwdata = 32'h1234_5678; smp();
      chk("raw_we", 32'(bus.mem_req & bus.mem_we), 32'd1);
      chk("raw_waddr", 32'(bus.mem_addr), 32'd8);
      nxt(); idle(); smp();
      chk("raw_wait", 32'(bus.hready), 32'd0);
      chk("raw_rreq", 32'(bus.mem_req & ~bus.mem_we), 32'd1);
      chk("raw_raddr", 32'(bus.mem_addr), 32'd8);
      nxt(); smp();
      chk("raw_hready", 32'(bus.hready), 32'd1);
      chk("raw_hrdata", bus.hrdata, 32'h1234_5678);
      // misaligned word read, then out-of-range halfword read
      for (int k = 0; k < 2; k++) begin
         nxt();
         if (k == 0) ap_set(1'b1, 2'b10, 3'd2, 32'h2, 1'b0);
         else ap_set(1'b1, 2'b10, 3'd1, 32'h0001_0000, 1'b0);
         smp(); chk("err_req_a", 32'(bus.mem_req), 32'd0);
         nxt(); idle(); smp();
         chk("err1", {30'd0, bus.hready, bus.hresp}, 32'b01);
         chk("err_req1", 32'(bus.mem_req), 32'd0);
         nxt(); smp();
         chk("err2", {30'd0, bus.hready, bus.hresp}, 32'b11);
         chk("err_req2", 32'(bus.mem_req), 32'd0);
      end
      // back-to-back halfword writes
      nxt(); ap_set(1'b1, 2'b10, 3'd1, 32'h0, 1'b1);
      for (int k = 1; k <= 4; k++) begin
         nxt();
         if (k < 4) ap_set(1'b1, 2'b11, 3'd1, 32'(2 * k), 1'b1); else idle();
         bus.hwdata = $urandom; smp();
         chk("b2b_be", 32'(bus.mem_be), (k % 2) ? 32'b0011 : 32'b1100);
         chk("b2b_ok", {29'd0, bus.mem_we, bus.hready, bus.hresp}, 32'b110);
      end
      // reset during a write data phase
      nxt(); ap_set(1'b1, 2'b10, 3'd2, 32'h30, 1'b1);
      nxt(); idle(); bus.hwdata = 32'hFFFF_FFFF; rst_n = 1'b0;
      nxt(); smp();
      chk("rstw_req", 32'(bus.mem_req), 32'd0);
      chk("rstw_resp", {30'd0, bus.hready, bus.hresp}, 32'b10);
      chk("rstw_sram", sram[12], pat(12));
      // randomized traffic against the reference model
      nxt(); do_init = 1'b1; nxt(); do_init = 1'b0; rst_n = 1'b1;
      gen(1'b1); model_on = 1'b1;
      for (int c = 0; c < 4000; c++) begin
         nxt();
         if (adv) begin
            was_wr   = dp_v && !dp_err && dp_wr;
            dp_v     = ap_v; dp_err = ap_err; dp_wr = ap_wr; dp_addr = ap_addr; dp_cyc = 0;
            dp_late  = was_wr && ap_v && !ap_err && !ap_wr;
            dp_be    = be_of(ap_size, ap_addr[1:0]);
            dp_wdata = $urandom; bus.hwdata = dp_wdata;
            gen(c >= 3990);
         end else dp_cyc++;
      end
      smp(); model_on = 1'b0;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
